ixc_regslice_7: RTL and testbench
=================================

Name: ixc_regslice_7

Overview:
- Registered valid/ready slice for a 7-bit bus, built as a two-entry skid buffer.
- Sits directly upstream of the 7-bit assign template in IXCOM_TEMP_LIBRARY. Its L output drives the assign's R input.
- Breaks the long combinational path ahead of the assign while sustaining one transfer per clock.
- Data order is preserved and no beat is ever dropped or duplicated.

Parameters:
- W, 7: data width. Fixed at 7 for this template and must match the downstream assign width.
- CNT_W, 8: width of the transfer counter. Used only when IXC_REGSLICE_CNT_EN is defined.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- R  input  W  upstream data.
- in_vld  input  1  upstream data valid.
- in_rdy  output  1  slice can accept data this cycle.
- L  output  W  registered data to the downstream assign R input.
- out_vld  output  1  L holds a valid beat.
- out_rdy  input  1  downstream accepts L this cycle.
- XCNT  output  CNT_W  transfer count. Present only with IXC_REGSLICE_CNT_EN.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Storage: main register (drives L) and skid register. 2-bit state: EMPTY, ONE, FULL.
- Handshakes:
  - Accept = in_vld & in_rdy.
  - Deliver = out_vld & out_rdy.
  - Upstream must hold R/in_vld stable until accepted. The slice never withdraws out_vld before delivery.
- Outputs:
  - out_vld = (state != EMPTY).
  - in_rdy = (state != FULL) & !rst. Both are decoded from registered state only; there is no combinational path from out_rdy or in_vld.
- Reset (sampled on clk edge while rst=1):
  - state=EMPTY, L=0, skid=0, out_vld=0.
  - in_rdy=0 for every cycle rst is high.
  - Reset mid-operation discards all held beats. There is no partial delivery.
- Transitions, EMPTY:
  - Accept: main<=R, go to ONE.
  - Otherwise stay in EMPTY.
- Transitions, ONE:
  - Accept & Deliver: main<=R, stay in ONE.
  - Accept & !Deliver: skid<=R, go to FULL.
  - !Accept & Deliver: go to EMPTY. L retains its last value and is not cleared.
  - Neither: hold.
- Transitions, FULL:
  - in_rdy=0, so no accept is possible.
  - Deliver: main<=skid, go to ONE.
  - Otherwise hold L and skid.
- Latency: a beat accepted at edge N appears on L with out_vld=1 after edge N (one cycle).
- Throughput: 1 beat/cycle when out_rdy is held high.
- Backpressure: out_rdy low for one cycle costs exactly one skid entry. in_rdy drops the cycle after FULL is entered.
- Data is never modified; width is W in and W out. No X is propagated from the skid into main during reset.
- No other states exist. Illegal state encoding 2'b11 recovers to EMPTY on the next edge.

Optional Feature:
- Macro IXC_REGSLICE_CNT_EN.
- Defined:
  - Adds output XCNT[CNT_W-1:0], incremented on every Deliver.
  - Wraps modulo 2^CNT_W (255 -> 0 for CNT_W=8) with no saturation.
  - Reset to 0 by rst.
  - Updates in the same edge as the transfer.
- Not defined: XCNT port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_vld=1, R=7'h55 -> in_rdy=0, out_vld=0, L=0 throughout. First accept occurs the cycle after rst drops.
- Streaming: out_rdy=1, R=1,2,3,4,5 on consecutive cycles -> L=1..5 on consecutive cycles, each one cycle after accept. in_rdy stays 1 and no bubbles appear.
- Backpressure: send 7'h11, 7'h22, 7'h33 with out_rdy=0 -> after 2 accepts state=FULL, in_rdy=0, L=7'h11. 7'h33 is held upstream. Raise out_rdy -> L sequence 11, 22, 33 with nothing lost.
- Drain: single beat 7'h7F with out_rdy=1 -> out_vld pulses one cycle, returns to EMPTY, L stays 7'h7F.
- Reset mid-operation: in FULL holding 7'h0A/7'h0B, assert rst one cycle -> out_vld=0, L=0. After release the first new beat 7'h0C is the next output; 0A/0B are never delivered.
- With IXC_REGSLICE_CNT_EN, CNT_W=8: 257 back-to-back deliveries -> XCNT ends at 1. rst returns it to 0.

Source files
------------

// File: rtl/ixc_regslice_7.sv
// Two-entry skid-buffer register slice for the 7-bit valid/ready bus feeding the assign template.
// Optional transfer counter output XCNT is enabled by defining IXC_REGSLICE_CNT_EN.
module ixc_regslice_7 #(
  parameter int W = 7
`ifdef IXC_REGSLICE_CNT_EN
  ,
  parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     R,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [W-1:0]     L,
  output logic             out_vld,
  input  logic             out_rdy
`ifdef IXC_REGSLICE_CNT_EN
  ,
  output logic [CNT_W-1:0] XCNT
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   main_q, main_d;
  logic [W-1:0]   skid_q, skid_d;
  logic           accept;
  logic           deliver;

  // Handshake decode uses registered state only; no path from out_rdy/in_vld.
  assign out_vld = (state_q == ONE) || (state_q == FULL);
  assign in_rdy  = ((state_q == EMPTY) || (state_q == ONE)) && !rst;
  assign L       = main_q;

  assign accept  = in_vld & in_rdy;
  assign deliver = out_vld & out_rdy;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          main_d  = R;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_d = R;
        end else if (accept) begin
          skid_d  = R;
          state_d = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef IXC_REGSLICE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Free-running wrap on overflow; no saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (deliver) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign XCNT = cnt_q;
`endif

endmodule

// File: tb/tb_ixc_regslice_7.sv
// Scoreboard bench for ixc_regslice_7: accepted beats are queued and checked in order on delivery.
module tb_ixc_regslice_7;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] R = '0;
  logic       in_vld = 1'b0;
  logic       in_rdy;
  logic [6:0] L;
  logic       out_vld;
  logic       out_rdy = 1'b0;
`ifdef IXC_REGSLICE_CNT_EN
  logic [7:0] XCNT;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [6:0] sb_q[$];
  logic [6:0] exp_l;

  ixc_regslice_7 dut (
    .clk(clk), .rst(rst), .R(R), .in_vld(in_vld), .in_rdy(in_rdy),
    .L(L), .out_vld(out_vld), .out_rdy(out_rdy)
`ifdef IXC_REGSLICE_CNT_EN
    , .XCNT(XCNT)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: inputs settle at negedge, so negedge+2 shows exactly what the next posedge samples.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (out_vld === 1'b1 && out_rdy) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL sb_underflow: delivered L=%h, expected no beat", L);
        end else begin
          exp_l = sb_q.pop_front();
          if (L !== exp_l) begin
            miscompares++;
            $display("FAIL sb_data: got L=%h, expected %h", L, exp_l);
          end
        end
      end
      if (in_vld && in_rdy === 1'b1) sb_q.push_back(R);
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_vld = 1'b1; R = 7'h55; out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b0 || L !== 7'h00) begin
        miscompares++;
        $display("FAIL reset_hold: in_rdy=%b out_vld=%b L=%h, expected 0 0 00", in_rdy, out_vld, L);
      end
    end
    @(negedge clk); rst = 1'b0; #3;
    vectors++;
    if (in_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_rdy: in_rdy=%b, expected 1", in_rdy);
    end
    @(posedge clk); #1;
    vectors++;
    if (out_vld !== 1'b1 || L !== 7'h55) begin
      miscompares++;
      $display("FAIL reset_first_accept: out_vld=%b L=%h, expected 1 55", out_vld, L);
    end
    @(negedge clk); in_vld = 1'b0; out_rdy = 1'b1;
    @(negedge clk); #3;
    vectors++;
    if (out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_drain: out_vld=%b, expected 0", out_vld);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); in_vld = 1'b1; R = 7'(i); out_rdy = 1'b1; #3;
      vectors++;
      if (in_rdy !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_rdy: beat %0d in_rdy=%b, expected 1", i, in_rdy);
      end
      if (i > 1) begin
        vectors++;
        if (out_vld !== 1'b1 || L !== 7'(i - 1)) begin
          miscompares++;
          $display("FAIL stream_out: out_vld=%b L=%h, expected 1 %h", out_vld, L, 7'(i - 1));
        end
      end
    end
    @(negedge clk); in_vld = 1'b0; #3;
    vectors++;
    if (out_vld !== 1'b1 || L !== 7'h05) begin
      miscompares++;
      $display("FAIL stream_last: out_vld=%b L=%h, expected 1 05", out_vld, L);
    end
    @(negedge clk); #3;
    vectors++;
    if (out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_empty: out_vld=%b, expected 0", out_vld);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk); out_rdy = 1'b0; in_vld = 1'b1; R = 7'h11;
    @(negedge clk); R = 7'h22; #3;
    vectors++;
    if (in_rdy !== 1'b1 || L !== 7'h11) begin
      miscompares++;
      $display("FAIL bp_one: in_rdy=%b L=%h, expected 1 11", in_rdy, L);
    end
    @(negedge clk); R = 7'h33;
    for (int i = 0; i < 2; i++) begin
      #3;
      vectors++;
      if (in_rdy !== 1'b0 || out_vld !== 1'b1 || L !== 7'h11) begin
        miscompares++;
        $display("FAIL bp_full: in_rdy=%b out_vld=%b L=%h, expected 0 1 11", in_rdy, out_vld, L);
      end
      @(negedge clk);
    end
    out_rdy = 1'b1; #3;
    vectors++;
    if (in_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release_rdy: in_rdy=%b, expected 0", in_rdy);
    end
    @(negedge clk); #3;
    vectors++;
    if (in_rdy !== 1'b1 || L !== 7'h22) begin
      miscompares++;
      $display("FAIL bp_second: in_rdy=%b L=%h, expected 1 22", in_rdy, L);
    end
    @(negedge clk); in_vld = 1'b0; #3;
    vectors++;
    if (out_vld !== 1'b1 || L !== 7'h33) begin
      miscompares++;
      $display("FAIL bp_third: out_vld=%b L=%h, expected 1 33", out_vld, L);
    end
    @(negedge clk);
  endtask

  task automatic test_drain();
    @(negedge clk); in_vld = 1'b1; R = 7'h7F; out_rdy = 1'b1;
    @(negedge clk); in_vld = 1'b0; #3;
    vectors++;
    if (out_vld !== 1'b1 || L !== 7'h7F) begin
      miscompares++;
      $display("FAIL drain_pulse: out_vld=%b L=%h, expected 1 7f", out_vld, L);
    end
    @(negedge clk); #3;
    vectors++;
    if (out_vld !== 1'b0 || L !== 7'h7F || in_rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_empty: out_vld=%b L=%h in_rdy=%b, expected 0 7f 1", out_vld, L, in_rdy);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); out_rdy = 1'b0; in_vld = 1'b1; R = 7'h0A;
    @(negedge clk); R = 7'h0B;
    @(negedge clk); in_vld = 1'b0; #3;
    vectors++;
    if (in_rdy !== 1'b0 || L !== 7'h0A) begin
      miscompares++;
      $display("FAIL mid_full: in_rdy=%b L=%h, expected 0 0a", in_rdy, L);
    end
    @(negedge clk); rst = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (out_vld !== 1'b0 || L !== 7'h00 || in_rdy !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: out_vld=%b L=%h in_rdy=%b, expected 0 00 0", out_vld, L, in_rdy);
    end
    @(negedge clk); rst = 1'b0; in_vld = 1'b1; R = 7'h0C;
    @(negedge clk); in_vld = 1'b0; #3;
    vectors++;
    if (out_vld !== 1'b1 || L !== 7'h0C) begin
      miscompares++;
      $display("FAIL mid_next: out_vld=%b L=%h, expected 1 0c", out_vld, L);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit acc = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!in_vld || acc) begin
        in_vld = ($urandom_range(0, 3) != 0);
        R = 7'($urandom);
      end
      out_rdy = ($urandom_range(0, 2) != 0);
      #3;
      acc = in_vld && (in_rdy === 1'b1);
    end
    @(negedge clk); in_vld = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 10 && (sb_q.size() != 0 || out_vld !== 1'b0); i++) @(negedge clk);
    #3;
    vectors++;
    if (sb_q.size() != 0 || out_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_drain: %0d beats pending out_vld=%b, expected 0 0", sb_q.size(), out_vld);
    end
  endtask

`ifdef IXC_REGSLICE_CNT_EN
  task automatic test_cnt();
    @(negedge clk); rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b1;
    @(negedge clk); rst = 1'b0; #3;
    vectors++;
    if (XCNT !== 8'd0) begin
      miscompares++;
      $display("FAIL cnt_reset: XCNT=%0d, expected 0", XCNT);
    end
    for (int i = 0; i < 257; i++) begin
      @(negedge clk); in_vld = 1'b1; R = 7'(i);
    end
    @(negedge clk); in_vld = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    vectors++;
    if (XCNT !== 8'd1) begin
      miscompares++;
      $display("FAIL cnt_wrap: XCNT=%0d, expected 1", XCNT);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #3;
    vectors++;
    if (XCNT !== 8'd0) begin
      miscompares++;
      $display("FAIL cnt_rst: XCNT=%0d, expected 0", XCNT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_back_to_back();
`ifdef IXC_REGSLICE_CNT_EN
    test_cnt();
`endif
    @(negedge clk); #3;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: %0d beats undelivered, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
